ssd_scan_driver: RTL and testbench
==================================

# ssd_scan_driver

Parametrised multiplexed seven-segment display driver for the board's anode/cathode display bank. It scans `NUM_DIGITS` common-anode digits from a packed hex word and adds per-digit enable, per-digit blink, and decimal-point control. A double-buffered load means a new display word never tears mid-frame. It sits between game/looper status logic and the `An*`, `Ca`–`Cg` and `Dp` pins, and replaces hand-written single-digit decode in top-level modules.

## Interface

Parameters:
- `NUM_DIGITS`, default 8: number of digits scanned (1–8).
- `SCAN_DIV_BITS`, default 18: scan prescaler width. One digit step occurs every 2^SCAN_DIV_BITS clocks.
- `BLINK_DIV_BITS`, default 25: blink counter width. The blink phase is the counter MSB.

Ports:
- `Clk`, input, 1: system clock. Single clock domain.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `load`, input, 1: single-cycle strobe. Captures `digits_in`, `digit_en`, `blink_mask` and `dp_in` into the staging register.
- `digits_in`, input, 4*NUM_DIGITS: packed hex values. Digit i is `[4i+3:4i]`.
- `digit_en`, input, NUM_DIGITS: 1 means the digit is lit; 0 means its anode stays off.
- `blink_mask`, input, NUM_DIGITS: 1 means the digit blanks during the blink phase.
- `dp_in`, input, NUM_DIGITS: 1 means the decimal point is lit for that digit.
- `An`, output, NUM_DIGITS: anodes, active-low, registered.
- `Cathodes`, output, 7: `{Ca,Cb,Cc,Cd,Ce,Cf,Cg}`, active-low, registered.
- `Dp`, output, 1: decimal-point cathode, active-low, registered.
- `scan_idx`, output, clog2(NUM_DIGITS) (minimum 1): index of the digit currently being driven.
- `frame_done`, output, 1: one-clock pulse when the scan wraps from the last digit to digit 0.
- `pending`, output, 1: staged data is waiting for the next frame boundary.

## Operation

- **Prescaler.** Free-running `SCAN_DIV_BITS` counter. `tick` is asserted when the counter equals all-ones.
- **Scan counter.** `scan_idx` increments on `tick`. When it is at `NUM_DIGITS-1`, it wraps to 0 instead. `wrap` = `tick` while at `NUM_DIGITS-1`.
- **Blink counter.** Free-running `BLINK_DIV_BITS` counter. `blink_phase` = counter MSB.
- **Double buffer.**
  - `load` writes the staging register and sets `pending`.
  - On `wrap`, the active register takes the staging value and `pending` clears.
  - Display outputs use only the active register.
- **Output stage**, computed for digit d = `scan_idx` from the active data:
  - If `digit_en[d]`=0, or (`blink_mask[d]`=1 and `blink_phase`=1): `An` = all ones, `Cathodes` = 7'h7F, `Dp` = 1.
  - Otherwise: `An` = all ones except bit d = 0, `Cathodes` = decode(hex d), `Dp` = ~`dp_in[d]`.
- **Decode table** (active-low, Ca..Cg):

  | Hex | Pattern |
  |-----|---------|
  | 0 | 0000001 |
  | 1 | 1001111 |
  | 2 | 0010010 |
  | 3 | 0000110 |
  | 4 | 1001100 |
  | 5 | 0100100 |
  | 6 | 0100000 |
  | 7 | 0001111 |
  | 8 | 0000000 |
  | 9 | 0000100 |
  | A | 0001000 |
  | b | 1100000 |
  | C | 0110001 |
  | d | 1000010 |
  | E | 0110000 |
  | F | 0111000 |

- **Reset (asserted).** All counters = 0, `scan_idx` = 0, staging and active registers = 0, `pending` = 0, `frame_done` = 0, `An` = all ones, `Cathodes` = 7'h7F, `Dp` = 1. Because the active `digit_en` is 0 after reset, the display stays dark until the first frame boundary after a `load`.

## Timing

- `An`, `Cathodes` and `Dp` are registered from the current `scan_idx`. The new digit appears one clock after `scan_idx` changes.
- Each digit is held for 2^SCAN_DIV_BITS clocks. One frame = `NUM_DIGITS` × 2^SCAN_DIV_BITS clocks.
- `frame_done` is high for exactly the clock following the `wrap` edge.
- Latency from `load` to visible output:
  - Minimum: 2 clocks, when `load` occurs one clock before `wrap`.
  - Maximum: one frame + 1 clock.
- **`load` coinciding with `wrap`.** The active register takes the old staging value. The new data is captured into staging and `pending` stays 1 until the next wrap.
- **Back-to-back `load`s within a frame.** Last write wins. Only the latest staging data is promoted.
- **`NUM_DIGITS` = 1.** `scan_idx` stays 0, `wrap` = `tick`, and `frame_done` pulses every 2^SCAN_DIV_BITS clocks.
- **`reset_n` asserted mid-frame.** Outputs blank immediately (asynchronously). Scanning restarts at digit 0, with the prescaler at 0, on the first clock after release.
- **Blink.** The blink phase is independent of the scan. Blanking of a blinking digit takes effect on the next output register update.

## Test plan

All scenarios use `NUM_DIGITS`=4, `SCAN_DIV_BITS`=2, `BLINK_DIV_BITS`=6.

1. **Reset.** Hold `reset_n`=0 for 3 clocks, then release. Required: `An`=4'hF, `Cathodes`=7'h7F, `Dp`=1 and `pending`=0 until the first post-load wrap.
2. **Basic scan.** Set `digit_en`=4'hF and `blink_mask`=0, `load` `digits_in`=16'h3210, wait for a wrap. Required: the digits cycle with `An` = E, D, B, 7, and `Cathodes` = 0000001, 1001111, 0010010, 0000110, each held for 4 clocks. `frame_done` pulses every 16 clocks.
3. **Tear-free load.** Issue `load` of 16'hFFFF while digit 1 is being driven. Required: the remainder of the frame still shows 2 and 3; F (0111000) appears only after the next wrap, and `pending` reads 1 until then.
4. **Load at wrap.** Assert `load` in the same cycle as `wrap`. Required: the new value is displayed one full frame later, not immediately.
5. **Blink, enable and decimal point.** Set `blink_mask`=4'b0010, `digit_en`=4'b1011, `dp_in`=4'b0001. Required:
   - Digit 2 is always blank.
   - Digit 1 is blank while `blink_phase`=1 (32-clock windows).
   - `Dp`=0 only while `An`=4'hE.
6. **Mid-frame reset.** Assert `reset_n`=0 during digit 2. Required: outputs blank within the same cycle, and `scan_idx`=0 after release.

Source files
------------

// File: rtl/ssd_scan_driver.sv
// Multiplexed common-anode seven-segment scanner with double-buffered display data,
// per-digit enable, blink and decimal point. All pin outputs are registered and active-low.
module ssd_scan_driver #(
    parameter int NUM_DIGITS     = 8,
    parameter int SCAN_DIV_BITS  = 18,
    parameter int BLINK_DIV_BITS = 25,
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                      Clk,
    input  logic                      reset_n,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    output logic [NUM_DIGITS-1:0]     An,
    output logic [6:0]                Cathodes,
    output logic                      Dp,
    output logic [IDX_W-1:0]          scan_idx,
    output logic                      frame_done,
    output logic                      pending
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [SCAN_DIV_BITS-1:0]  r_prescale;
    logic [BLINK_DIV_BITS-1:0] r_blink;
    logic [IDX_W-1:0]          r_scan_idx;
    logic                      r_frame_done;
    logic                      r_pending;

    logic [4*NUM_DIGITS-1:0]   r_stg_digits;
    logic [NUM_DIGITS-1:0]     r_stg_en;
    logic [NUM_DIGITS-1:0]     r_stg_bm;
    logic [NUM_DIGITS-1:0]     r_stg_dp;
    logic [4*NUM_DIGITS-1:0]   r_act_digits;
    logic [NUM_DIGITS-1:0]     r_act_en;
    logic [NUM_DIGITS-1:0]     r_act_bm;
    logic [NUM_DIGITS-1:0]     r_act_dp;

    logic [NUM_DIGITS-1:0]     r_an;
    logic [6:0]                r_cath;
    logic                      r_dp;

    logic                      w_tick;
    logic                      w_wrap;
    logic                      w_blink_phase;
    logic [3:0]                w_hex;
    logic                      w_en;
    logic                      w_bm;
    logic                      w_dp;
    logic                      w_blank;

    function automatic logic [6:0] decode(input logic [3:0] hex);
        case (hex)
            4'h0: decode = 7'b0000001;
            4'h1: decode = 7'b1001111;
            4'h2: decode = 7'b0010010;
            4'h3: decode = 7'b0000110;
            4'h4: decode = 7'b1001100;
            4'h5: decode = 7'b0100100;
            4'h6: decode = 7'b0100000;
            4'h7: decode = 7'b0001111;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0000100;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b1100000;
            4'hC: decode = 7'b0110001;
            4'hD: decode = 7'b1000010;
            4'hE: decode = 7'b0110000;
            default: decode = 7'b0111000;
        endcase
    endfunction

    assign w_tick        = &r_prescale;
    assign w_wrap        = w_tick && (r_scan_idx == LAST_IDX);
    assign w_blink_phase = r_blink[BLINK_DIV_BITS-1];

    // Loop-based select avoids out-of-range indexing when NUM_DIGITS is not a power of two.
    always_comb begin
        w_hex = 4'h0;
        w_en  = 1'b0;
        w_bm  = 1'b0;
        w_dp  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_scan_idx == IDX_W'(i)) begin
                w_hex = r_act_digits[4*i +: 4];
                w_en  = r_act_en[i];
                w_bm  = r_act_bm[i];
                w_dp  = r_act_dp[i];
            end
        end
    end

    assign w_blank = !w_en || (w_bm && w_blink_phase);

    // load is a single-cycle strobe with no back-pressure: it always lands in staging,
    // and staging is promoted to active only on the frame wrap, so a frame never tears.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prescale   <= '0;
            r_blink      <= '0;
            r_scan_idx   <= '0;
            r_frame_done <= 1'b0;
            r_pending    <= 1'b0;
            r_stg_digits <= '0;
            r_stg_en     <= '0;
            r_stg_bm     <= '0;
            r_stg_dp     <= '0;
            r_act_digits <= '0;
            r_act_en     <= '0;
            r_act_bm     <= '0;
            r_act_dp     <= '0;
            r_an         <= '1;
            r_cath       <= 7'h7F;
            r_dp         <= 1'b1;
        end else begin
            r_prescale   <= r_prescale + SCAN_DIV_BITS'(1);
            r_blink      <= r_blink + BLINK_DIV_BITS'(1);
            r_frame_done <= w_wrap;

            if (w_wrap) begin
                r_scan_idx <= '0;
            end else if (w_tick) begin
                r_scan_idx <= r_scan_idx + IDX_W'(1);
            end

            if (w_wrap) begin
                r_act_digits <= r_stg_digits;
                r_act_en     <= r_stg_en;
                r_act_bm     <= r_stg_bm;
                r_act_dp     <= r_stg_dp;
            end

            // A load on the wrap edge keeps pending set: its data waits for the next frame.
            if (load) begin
                r_stg_digits <= digits_in;
                r_stg_en     <= digit_en;
                r_stg_bm     <= blink_mask;
                r_stg_dp     <= dp_in;
                r_pending    <= 1'b1;
            end else if (w_wrap) begin
                r_pending    <= 1'b0;
            end

            if (w_blank) begin
                r_an   <= '1;
                r_cath <= 7'h7F;
                r_dp   <= 1'b1;
            end else begin
                r_an   <= ~(NUM_DIGITS'(1) << r_scan_idx);
                r_cath <= decode(w_hex);
                r_dp   <= ~w_dp;
            end
        end
    end

    assign An         = r_an;
    assign Cathodes   = r_cath;
    assign Dp         = r_dp;
    assign scan_idx   = r_scan_idx;
    assign frame_done = r_frame_done;
    assign pending    = r_pending;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver (4 digits, 4-clock digit slots, 64-clock blink period):
// a cycle-count based reference model checks every output after every clock edge.
module tb_ssd_scan_driver;

    logic        Clk;
    logic        reset_n;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  digit_en;
    logic [3:0]  blink_mask;
    logic [3:0]  dp_in;
    logic [3:0]  An;
    logic [6:0]  Cathodes;
    logic        Dp;
    logic [1:0]  scan_idx;
    logic        frame_done;
    logic        pending;

    ssd_scan_driver #(
        .NUM_DIGITS    (4),
        .SCAN_DIV_BITS (2),
        .BLINK_DIV_BITS(6)
    ) dut (
        .Clk       (Clk),
        .reset_n   (reset_n),
        .load      (load),
        .digits_in (digits_in),
        .digit_en  (digit_en),
        .blink_mask(blink_mask),
        .dp_in     (dp_in),
        .An        (An),
        .Cathodes  (Cathodes),
        .Dp        (Dp),
        .scan_idx  (scan_idx),
        .frame_done(frame_done),
        .pending   (pending)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0] hex;
        logic [6:0] cath;
    } dec_vec_t;

    dec_vec_t vecs[16];

    int n_vec = 0;
    int n_err = 0;

    // Reference state: k counts clock edges since reset release, which fixes prescaler,
    // scan position and blink phase arithmetically.
    int          k;
    logic [15:0] m_stg_dig, m_act_dig;
    logic [3:0]  m_stg_en, m_act_en, m_stg_bm, m_act_bm, m_stg_dp, m_act_dp;
    logic        m_pend;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", nm, act, exp, k);
        end
    endtask

    task automatic reset_model();
        k         = 0;
        m_stg_dig = '0; m_act_dig = '0;
        m_stg_en  = '0; m_act_en  = '0;
        m_stg_bm  = '0; m_act_bm  = '0;
        m_stg_dp  = '0; m_act_dp  = '0;
        m_pend    = 1'b0;
    endtask

    task automatic chk_blank(input string nm);
        chk({nm, "_an"},    32'(An),         32'hF);
        chk({nm, "_cath"},  32'(Cathodes),   32'h7F);
        chk({nm, "_dp"},    32'(Dp),         32'h1);
        chk({nm, "_idx"},   32'(scan_idx),   32'h0);
        chk({nm, "_pend"},  32'(pending),    32'h0);
        chk({nm, "_fdone"}, 32'(frame_done), 32'h0);
    endtask

    task automatic tick(input logic ld);
        logic [3:0] exp_an;
        logic [6:0] exp_cath;
        logic       exp_dp;
        logic [3:0] hex;
        int         idx;
        bit         phase, wrap;
        load = ld;
        @(posedge Clk);
        idx   = (k / 4) % 4;
        phase = (k % 64) >= 32;
        wrap  = (k % 16) == 15;
        if (m_act_en[idx] && !(m_act_bm[idx] && phase)) begin
            exp_an      = 4'hF;
            exp_an[idx] = 1'b0;
            hex         = m_act_dig[idx*4 +: 4];
            exp_cath    = vecs[hex].cath;
            exp_dp      = ~m_act_dp[idx];
        end else begin
            exp_an   = 4'hF;
            exp_cath = 7'h7F;
            exp_dp   = 1'b1;
        end
        if (wrap) begin
            m_act_dig = m_stg_dig; m_act_en = m_stg_en;
            m_act_bm  = m_stg_bm;  m_act_dp = m_stg_dp;
        end
        if (ld) begin
            m_stg_dig = digits_in; m_stg_en = digit_en;
            m_stg_bm  = blink_mask; m_stg_dp = dp_in;
            m_pend    = 1'b1;
        end else if (wrap) begin
            m_pend = 1'b0;
        end
        k++;
        #1;
        chk("an",       32'(An),         32'(exp_an));
        chk("cathodes", 32'(Cathodes),   32'(exp_cath));
        chk("dp",       32'(Dp),         32'(exp_dp));
        chk("scan_idx", 32'(scan_idx),   32'((k / 4) % 4));
        chk("frame_done", 32'(frame_done), 32'(wrap));
        chk("pending",  32'(pending),    32'(m_pend));
        load = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    // Advance until the next edge to be applied has index k with k%16 == pos (at most 16 edges).
    task automatic run_to(input int pos);
        for (int i = 0; i < 16 && (k % 16) != pos; i++) tick(1'b0);
    endtask

    task automatic set_inputs(input logic [15:0] d, input logic [3:0] en,
                              input logic [3:0] bm, input logic [3:0] dp);
        digits_in  = d;
        digit_en   = en;
        blink_mask = bm;
        dp_in      = dp;
    endtask

    initial begin
        vecs[0]  = '{4'h0, 7'b0000001};
        vecs[1]  = '{4'h1, 7'b1001111};
        vecs[2]  = '{4'h2, 7'b0010010};
        vecs[3]  = '{4'h3, 7'b0000110};
        vecs[4]  = '{4'h4, 7'b1001100};
        vecs[5]  = '{4'h5, 7'b0100100};
        vecs[6]  = '{4'h6, 7'b0100000};
        vecs[7]  = '{4'h7, 7'b0001111};
        vecs[8]  = '{4'h8, 7'b0000000};
        vecs[9]  = '{4'h9, 7'b0000100};
        vecs[10] = '{4'hA, 7'b0001000};
        vecs[11] = '{4'hB, 7'b1100000};
        vecs[12] = '{4'hC, 7'b0110001};
        vecs[13] = '{4'hD, 7'b1000010};
        vecs[14] = '{4'hE, 7'b0110000};
        vecs[15] = '{4'hF, 7'b0111000};

        reset_n = 1'b0;
        load    = 1'b0;
        set_inputs(16'h0, 4'h0, 4'h0, 4'h0);
        reset_model();

        // Reset held for three clocks; display must stay dark with nothing loaded.
        repeat (3) @(posedge Clk);
        #1 chk_blank("reset");
        @(negedge Clk);
        reset_n = 1'b1;
        run(20);

        // Basic scan of 3,2,1,0 with all digits enabled.
        set_inputs(16'h3210, 4'hF, 4'h0, 4'h0);
        tick(1'b1);
        run(40);
        run_to(0);

        // Tear-free load of FFFF while digit 1 is on the pins.
        run_to(6);
        set_inputs(16'hFFFF, 4'hF, 4'h0, 4'h0);
        tick(1'b1);
        chk("tear_pending", 32'(pending), 32'h1);
        run(20);

        // Load coinciding with wrap: old staging promoted, new value one frame later.
        run_to(14);
        set_inputs(16'h89AB, 4'hF, 4'h0, 4'h0);
        tick(1'b1);
        run_to(15);
        set_inputs(16'h4567, 4'hF, 4'h0, 4'h0);
        tick(1'b1);
        tick(1'b0);
        chk("wrapload_old", 32'(Cathodes), 32'(vecs[11].cath));
        chk("wrapload_pend", 32'(pending), 32'h1);
        run_to(0);
        tick(1'b0);
        chk("wrapload_new", 32'(Cathodes), 32'(vecs[7].cath));
        run(16);

        // Decode table: each hex value on all four digits.
        for (int v = 0; v < 16; v++) begin
            run_to(14);
            set_inputs({4{vecs[v].hex}}, 4'hF, 4'h0, 4'h0);
            tick(1'b1);
            tick(1'b0);
            tick(1'b0);
            chk("decode_tbl", 32'(Cathodes), 32'(vecs[v].cath));
        end

        // Blink on digit 1, digit 2 disabled, decimal point on digit 0; two blink periods.
        set_inputs(16'h7654, 4'b1011, 4'b0010, 4'b0001);
        tick(1'b1);
        run(160);

        // Mid-frame reset while digit 2 is lit.
        set_inputs(16'hC0DE, 4'hF, 4'h0, 4'h0);
        tick(1'b1);
        run(20);
        run_to(10);
        chk("pre_reset_an", 32'(An), 32'hB);
        #2 reset_n = 1'b0;
        #1 chk_blank("async_reset");
        @(posedge Clk);
        #1 chk_blank("held_reset");
        @(negedge Clk);
        reset_n = 1'b1;
        reset_model();
        tick(1'b0);
        chk("post_reset_idx", 32'(scan_idx), 32'h0);
        run(10);

        // Randomized loads of random display data at random times.
        for (int i = 0; i < 800; i++) begin
            set_inputs(16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            tick(($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
